// File: rtl/i2s_tx_framer_if.sv
// Sample-pair handshake from the effects pipeline into the I2S transmitter.
// The source drives one stereo pair at a time with valid; the framer answers with ready.
interface i2s_tx_framer_if #(
   parameter int DATA_W = 24
) ();
   logic [DATA_W-1:0] in_left;
   logic [DATA_W-1:0] in_right;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_left,
      output in_right,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_left,
      input  in_right,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/i2s_tx_framer.sv
// Stereo I2S / left-justified serial transmitter with a one-pair buffer.
// Everything runs on the falling edge of sclk; master generates LRCLK, slave follows lrclk_in.
//
// buf_state | meaning
// ----------+-------------------------------------------------------------
// BUF_EMPTY | no pair waiting; in_ready high, next accept fills the buffer
// BUF_FULL  | pair waiting; moved into the frame registers at frame start
module i2s_tx_framer #(
   parameter int DATA_W        = 24,
   parameter int SLOT_W        = 32,
   parameter bit MASTER        = 1'b1,
   parameter bit LJ_MODE       = 1'b0,
   parameter bit UNDERRUN_HOLD = 1'b0
) (
   input  logic           sclk,
   input  logic           rst_n,
   input  logic           lrclk_in,
   output logic           lrclk_out,
   i2s_tx_framer_if.slave smp,
   output logic           sdout,
   output logic           underrun
);

   localparam int               POS_W   = $clog2(SLOT_W + 1);
   localparam logic [POS_W-1:0] POS_MAX = '1;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   buf_state_t        buf_state;
   buf_state_t        buf_next;

   logic              frame_load;
   logic              slot_d;
   logic [POS_W-1:0]  pos_d;
   logic              accept;
   logic              load_buf;

   logic [DATA_W-1:0] buf_left;
   logic [DATA_W-1:0] buf_right;
   logic [DATA_W-1:0] cur_left;
   logic [DATA_W-1:0] cur_right;
   logic [DATA_W-1:0] cur_left_d;
   logic [DATA_W-1:0] cur_right_d;

   generate
      if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
         $error("i2s_tx_framer: DATA_W must be in 8..32");
      end
      if (SLOT_W < DATA_W + 1) begin : g_bad_slot_w
         $error("i2s_tx_framer: SLOT_W must be at least DATA_W+1");
      end
      if (LJ_MODE && !MASTER) begin : g_bad_lj
         $error("i2s_tx_framer: left-justified mode needs MASTER=1");
      end
   endgenerate

   // Slot timing: produces the slot/position the next edge moves to and flags frame start.
   generate
      if (MASTER) begin : g_master
         localparam int               CNT_W    = $clog2(2 * SLOT_W);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
         localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             run_q;
         logic             lrclk_q;
         logic             lrclk_unused;

         assign lrclk_unused = lrclk_in;

         // run_q makes the first edge after reset a frame start at cnt=0.
         always_comb begin
            frame_load = 1'b0;
            cnt_d      = cnt_q + 1'b1;
            if (!run_q || cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               frame_load = 1'b1;
            end
            slot_d = (cnt_d >= SLOT_LEN);
            pos_d  = slot_d ? POS_W'(cnt_d - SLOT_LEN) : POS_W'(cnt_d);
         end

         always_ff @(negedge sclk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q   <= '0;
               run_q   <= 1'b0;
               lrclk_q <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               run_q   <= 1'b1;
               lrclk_q <= slot_d;
            end
         end

         assign lrclk_out = lrclk_q;
      end else begin : g_slave
         logic             lr_q;
         logic [POS_W-1:0] pos_q;

         // A change seen on this edge means one SCLK of the new slot has already elapsed.
         always_comb begin
            frame_load = lr_q & ~lrclk_in;
            slot_d     = lrclk_in;
            if (lrclk_in != lr_q) begin
               pos_d = POS_W'(1);
            end else if (pos_q == POS_MAX) begin
               pos_d = pos_q;
            end else begin
               pos_d = pos_q + 1'b1;
            end
         end

         always_ff @(negedge sclk or negedge rst_n) begin
            if (!rst_n) begin
               lr_q  <= 1'b0;
               pos_q <= '0;
            end else begin
               lr_q  <= lrclk_in;
               pos_q <= pos_d;
            end
         end

         assign lrclk_out = lr_q;
      end
   endgenerate

   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         buf_state <= BUF_EMPTY;
      end else begin
         buf_state <= buf_next;
      end
   end

   always_comb begin
      buf_next = buf_state;
      case (buf_state)
         BUF_EMPTY: if (smp.in_valid) buf_next = BUF_FULL;
         BUF_FULL:  if (frame_load)   buf_next = BUF_EMPTY;
         default:   buf_next = BUF_EMPTY;
      endcase
   end

   always_comb begin
      smp.in_ready = (buf_state == BUF_EMPTY);
      accept       = smp.in_valid && (buf_state == BUF_EMPTY);
      load_buf     = frame_load && (buf_state == BUF_FULL);
   end

   always_comb begin
      cur_left_d  = cur_left;
      cur_right_d = cur_right;
      if (load_buf) begin
         cur_left_d  = buf_left;
         cur_right_d = buf_right;
      end else if (frame_load && !UNDERRUN_HOLD) begin
         cur_left_d  = '0;
         cur_right_d = '0;
      end
   end

   function automatic logic tx_bit(input logic [DATA_W-1:0] word,
                                   input logic [POS_W-1:0]  pos);
      int                p;
      logic [DATA_W-1:0] shifted;
      p       = int'(pos);
      shifted = word;
      tx_bit  = 1'b0;
      if (LJ_MODE) begin
         if (p < DATA_W) begin
            shifted = word >> (DATA_W - 1 - p);
            tx_bit  = shifted[0];
         end
      end else if (p >= 1 && p <= DATA_W) begin
         shifted = word >> (DATA_W - p);
         tx_bit  = shifted[0];
      end
   endfunction

   // sdout uses the post-edge frame contents so the load edge carries no extra latency.
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         buf_left  <= '0;
         buf_right <= '0;
         cur_left  <= '0;
         cur_right <= '0;
         sdout     <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (accept) begin
            buf_left  <= smp.in_left;
            buf_right <= smp.in_right;
         end
         cur_left  <= cur_left_d;
         cur_right <= cur_right_d;
         sdout     <= tx_bit(slot_d ? cur_right_d : cur_left_d, pos_d);
         underrun  <= frame_load && (buf_state == BUF_EMPTY);
      end
   end

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Randomized bench for i2s_tx_framer: master I2S, master left-justified with hold, and slave I2S
// instances run side by side against a frame-level reference model.
module tb_i2s_tx_framer;

   localparam int NDUT = 3;
   localparam int D0 = 24;
   localparam int S0 = 32;
   localparam int D1 = 16;
   localparam int S1 = 20;
   localparam int D2 = 24;
   localparam int S2 = 32;

   logic sclk     = 1'b0;
   logic rst_n    = 1'b1;
   logic lrclk_in = 1'b1;

   always #5 sclk = ~sclk;

   int cfg_s    [NDUT] = '{S0, S1, S2};
   int cfg_d    [NDUT] = '{D0, D1, D2};
   bit cfg_m    [NDUT] = '{1'b1, 1'b1, 1'b0};
   bit cfg_lj   [NDUT] = '{1'b0, 1'b1, 1'b0};
   bit cfg_hold [NDUT] = '{1'b0, 1'b1, 1'b1};

   logic [31:0] drv_l [NDUT];
   logic [31:0] drv_r [NDUT];
   logic        drv_v [NDUT];

   wire [NDUT-1:0] sd;
   wire [NDUT-1:0] lr;
   wire [NDUT-1:0] ur;
   wire [NDUT-1:0] rdy;

   i2s_tx_framer_if #(.DATA_W(D0)) smp0 ();
   i2s_tx_framer_if #(.DATA_W(D1)) smp1 ();
   i2s_tx_framer_if #(.DATA_W(D2)) smp2 ();

   assign smp0.in_left  = drv_l[0][D0-1:0];
   assign smp0.in_right = drv_r[0][D0-1:0];
   assign smp0.in_valid = drv_v[0];
   assign smp1.in_left  = drv_l[1][D1-1:0];
   assign smp1.in_right = drv_r[1][D1-1:0];
   assign smp1.in_valid = drv_v[1];
   assign smp2.in_left  = drv_l[2][D2-1:0];
   assign smp2.in_right = drv_r[2][D2-1:0];
   assign smp2.in_valid = drv_v[2];
   assign rdy = {smp2.in_ready, smp1.in_ready, smp0.in_ready};

   i2s_tx_framer #(.DATA_W(D0), .SLOT_W(S0), .MASTER(1'b1), .LJ_MODE(1'b0), .UNDERRUN_HOLD(1'b0)) dut_i2s (
      .sclk(sclk), .rst_n(rst_n), .lrclk_in(lrclk_in), .lrclk_out(lr[0]),
      .smp(smp0), .sdout(sd[0]), .underrun(ur[0]));

   i2s_tx_framer #(.DATA_W(D1), .SLOT_W(S1), .MASTER(1'b1), .LJ_MODE(1'b1), .UNDERRUN_HOLD(1'b1)) dut_lj (
      .sclk(sclk), .rst_n(rst_n), .lrclk_in(lrclk_in), .lrclk_out(lr[1]),
      .smp(smp1), .sdout(sd[1]), .underrun(ur[1]));

   i2s_tx_framer #(.DATA_W(D2), .SLOT_W(S2), .MASTER(1'b0), .LJ_MODE(1'b0), .UNDERRUN_HOLD(1'b1)) dut_slv (
      .sclk(sclk), .rst_n(rst_n), .lrclk_in(lrclk_in), .lrclk_out(lr[2]),
      .smp(smp2), .sdout(sd[2]), .underrun(ur[2]));

   // Reference model state: one stereo pair waiting, one pair on the wire.
   int          m_edges  [NDUT];
   int          m_pos    [NDUT];
   bit          m_lrprev [NDUT];
   bit          m_full   [NDUT];
   logic [31:0] m_bl     [NDUT];
   logic [31:0] m_br     [NDUT];
   logic [31:0] m_cl     [NDUT];
   logic [31:0] m_cr     [NDUT];
   bit          e_sd     [NDUT];
   bit          e_lr     [NDUT];
   bit          e_ur     [NDUT];
   bit          e_rdy    [NDUT];

   int n_tests = 0;
   int n_fail  = 0;

   int slot_seq [$] = '{32, 40, 20, 32, 100, 25, 33};
   int lr_left = 6;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input int d);
      return (d >= 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 32'd1);
   endfunction

   function automatic int sat_max(input int s);
      int m = 1;
      while (m < s + 1) m = m * 2;
      return m - 1;
   endfunction

   // MSB-first: I2S puts the MSB one SCLK after the slot starts, LJ on the first SCLK.
   function automatic bit bit_of(input logic [31:0] w, input int pos, input int d, input bit lj);
      int idx;
      idx = lj ? (d - 1 - pos) : (d - pos);
      if (idx < 0 || idx >= d) return 1'b0;
      return w[idx];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_edges[k]  = 0;
         m_pos[k]    = 0;
         m_lrprev[k] = 1'b0;
         m_full[k]   = 1'b0;
         m_bl[k]     = '0;
         m_br[k]     = '0;
         m_cl[k]     = '0;
         m_cr[k]     = '0;
         e_sd[k]     = 1'b0;
         e_lr[k]     = 1'b0;
         e_ur[k]     = 1'b0;
         e_rdy[k]    = 1'b1;
      end
   endtask

   task automatic model_edge(input int k);
      int          ph;
      int          pos;
      bit          slot;
      bit          start;
      bit          pre_full;
      logic [31:0] w;
      if (cfg_m[k]) begin
         ph    = m_edges[k] % (2 * cfg_s[k]);
         slot  = (ph >= cfg_s[k]);
         pos   = ph % cfg_s[k];
         start = (ph == 0);
         m_edges[k]++;
      end else begin
         start = m_lrprev[k] && !lrclk_in;
         if (lrclk_in != m_lrprev[k]) m_pos[k] = 1;
         else if (m_pos[k] < sat_max(cfg_s[k])) m_pos[k]++;
         m_lrprev[k] = lrclk_in;
         slot = lrclk_in;
         pos  = m_pos[k];
      end
      pre_full = m_full[k];
      if (start) begin
         if (pre_full) begin
            m_cl[k]   = m_bl[k];
            m_cr[k]   = m_br[k];
            m_full[k] = 1'b0;
         end else if (!cfg_hold[k]) begin
            m_cl[k] = '0;
            m_cr[k] = '0;
         end
      end
      if (drv_v[k] && !pre_full) begin
         m_bl[k]   = drv_l[k] & mask_of(cfg_d[k]);
         m_br[k]   = drv_r[k] & mask_of(cfg_d[k]);
         m_full[k] = 1'b1;
      end
      w        = slot ? m_cr[k] : m_cl[k];
      e_sd[k]  = bit_of(w, pos, cfg_d[k], cfg_lj[k]);
      e_lr[k]  = slot;
      e_ur[k]  = start && !pre_full;
      e_rdy[k] = !m_full[k];
   endtask

   task automatic check_outputs(input string phase);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("%s.d%0d.sdout", phase, k), 32'(sd[k]), 32'(e_sd[k]));
         check($sformatf("%s.d%0d.lrclk", phase, k), 32'(lr[k]), 32'(e_lr[k]));
         check($sformatf("%s.d%0d.underrun", phase, k), 32'(ur[k]), 32'(e_ur[k]));
         check($sformatf("%s.d%0d.in_ready", phase, k), 32'(rdy[k]), 32'(e_rdy[k]));
      end
   endtask

   task automatic drive_inputs(input int valid_pct);
      for (int k = 0; k < NDUT; k++) begin
         drv_v[k] = ($urandom_range(99, 0) < valid_pct);
         drv_l[k] = $urandom & mask_of(cfg_d[k]);
         drv_r[k] = $urandom & mask_of(cfg_d[k]);
      end
      if (lr_left == 0) begin
         lrclk_in = ~lrclk_in;
         lr_left  = (slot_seq.size() > 0) ? slot_seq.pop_front() : int'($urandom_range(48, 8));
      end
      lr_left--;
   endtask

   task automatic run_cycles(input int n, input int valid_pct, input string phase);
      for (int c = 0; c < n; c++) begin
         drive_inputs(valid_pct);
         @(negedge sclk);
         for (int k = 0; k < NDUT; k++) model_edge(k);
         @(posedge sclk);
         check_outputs(phase);
      end
   endtask

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         drv_v[k] = 1'b0;
         drv_l[k] = '0;
         drv_r[k] = '0;
      end
      model_reset();
      #1 rst_n = 1'b0;
      @(posedge sclk);
      check_outputs("reset");
      @(posedge sclk);
      check_outputs("reset");
      #2 rst_n = 1'b1;

      run_cycles(300, 0, "idle");
      run_cycles(200, 3, "sparse");
      run_cycles(400, 100, "stream");
      run_cycles(300, 20, "random");
      run_cycles(20, 100, "prefill");

      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs("rst_assert");
      repeat (3) begin
         @(posedge sclk);
         check_outputs("in_reset");
      end
      #2 rst_n = 1'b1;

      run_cycles(300, 10, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
